u_ifu_fetch_queue: RTL and testbench
====================================

// Module: u_ifu_fetch_queue
// PURPOSE
//   Receiving end of the PC generator's fetch stream. Buffers the 64-bit fetch packets (two 32-bit
//   instructions at pc and pc+4) returned from instruction memory, then hands instructions to decode
//   one per cycle over a valid/ready interface. Carries the pc-unaligned flag through to decode.
//   Drops all buffered packets on a BRU flush.
// PARAMETERS
//   DEPTH       4   packet entries; power of two, >= 2
//   PC_WIDTH    32  pc width; equals `PC_WIDTH
//   INST_WIDTH  32  instruction width
// PORTS
//   clk             in   1           single clock; all state updates on the rising edge
//   rst             in   1           reset: synchronous, active-high
//   fq_in_valid     in   1           fetch packet present
//   fq_in_ready     out  1           queue accepts a packet this cycle
//   fq_in_pc        in   PC_WIDTH    pc of slot 0
//   fq_in_inst0     in   INST_WIDTH  instruction at pc
//   fq_in_inst1     in   INST_WIDTH  instruction at pc+4
//   fq_in_unalign   in   1           pc was unaligned (is_pc_unalign)
//   bru_flush       in   1           branch redirect; discard all contents
//   fq_out_valid    out  1           instruction available to decode
//   fq_out_ready    in   1           decode consumes this cycle
//   fq_out_pc       out  PC_WIDTH    pc of the presented instruction
//   fq_out_inst     out  INST_WIDTH  presented instruction
//   fq_out_unalign  out  1           presented pc was unaligned; decode raises the exception
//   fq_count        out  clog2(DEPTH+1)  occupied packet entries
// BEHAVIOUR
//   Reset: rd_ptr=wr_ptr=0, count=0, slot_sel=0. Outputs: fq_in_ready=1, fq_out_valid=0,
//     fq_count=0. fq_out_pc/inst/unalign=0 while fq_out_valid=0.
//   Push: fq_in_valid & fq_in_ready & ~bru_flush writes {pc,inst0,inst1,unalign} at wr_ptr.
//     wr_ptr increments and wraps DEPTH-1 -> 0.
//   fq_in_ready = (count != DEPTH); combinational from count only, not from fq_out_ready.
//     No push when full, even in a pop cycle.
//   Output (fall-through from head entry): fq_out_valid = (count != 0).
//     - Entry written at edge N is visible at fq_out_valid in cycle N+1.
//     - slot_sel=0: pc=head.pc, inst=head.inst0.
//     - slot_sel=1: pc=head.pc+4 (PC_WIDTH modulo, wraps), inst=head.inst1.
//     - fq_out_unalign = head.unalign.
//   Consume (fq_out_valid & fq_out_ready & ~bru_flush):
//     - aligned entry, slot_sel=0 -> slot_sel=1; entry stays.
//     - aligned entry, slot_sel=1 -> slot_sel=0; pop (rd_ptr++ with wrap, count--).
//     - unaligned entry -> pop after slot 0; inst1 is never presented.
//   Simultaneous push and pop: count unchanged, both pointers advance.
//   bru_flush (overrides everything):
//     - next edge sets rd_ptr=wr_ptr=0, count=0, slot_sel=0.
//     - a same-cycle push is dropped; a same-cycle consume is ignored.
//     - fq_out_valid=0 in the following cycle.
//   rst mid-operation: identical to flush plus reset values; contents discarded, no stale output.
//   Storage contents need no reset; only pointers, count and slot_sel are reset.
//   Decode holding fq_out_ready=0 leaves outputs stable until consume or flush.
// TESTING
//   1 Reset, push pc=0x100 inst0=0xA inst1=0xB -> next cycle out (0x100,0xA),
//     then (0x104,0xB), then fq_out_valid=0, fq_count=0.
//   2 Push 4 packets with fq_out_ready=0 -> fq_count=4, fq_in_ready=0.
//     5th packet is not accepted. One full pop -> fq_in_ready=1.
//   3 Push pc=0x102 unalign=1 -> out (0x102, inst0, unalign=1) for one instruction only,
//     then the next entry.
//   4 Queue holding 3 entries, slot_sel=1, bru_flush with a push on the same cycle ->
//     next cycle fq_count=0, fq_out_valid=0. Next push appears at slot 0.
//   5 Continuous push and pop for 3*DEPTH packets -> in-order pcs, pointer wrap correct,
//     pc=0xFFFFFFFC slot1 gives 0x00000000.
//   6 rst asserted while 2 entries are held -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/u_ifu_fetch_queue_if.sv
// rtl/u_ifu_fetch_queue_if.sv - fetch packet in / instruction out handshake bundle
interface u_ifu_fetch_queue_if #(
    parameter int DEPTH      = 4,
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  fq_in_valid;
    logic                  fq_in_ready;
    logic [PC_WIDTH-1:0]   fq_in_pc;
    logic [INST_WIDTH-1:0] fq_in_inst0;
    logic [INST_WIDTH-1:0] fq_in_inst1;
    logic                  fq_in_unalign;
    logic                  bru_flush;
    logic                  fq_out_valid;
    logic                  fq_out_ready;
    logic [PC_WIDTH-1:0]   fq_out_pc;
    logic [INST_WIDTH-1:0] fq_out_inst;
    logic                  fq_out_unalign;
    logic [CW-1:0]         fq_count;

    modport master (
        output fq_in_valid, fq_in_pc, fq_in_inst0, fq_in_inst1, fq_in_unalign,
        output bru_flush, fq_out_ready,
        input  fq_in_ready, fq_out_valid, fq_out_pc, fq_out_inst, fq_out_unalign, fq_count
    );

    modport slave (
        input  fq_in_valid, fq_in_pc, fq_in_inst0, fq_in_inst1, fq_in_unalign,
        input  bru_flush, fq_out_ready,
        output fq_in_ready, fq_out_valid, fq_out_pc, fq_out_inst, fq_out_unalign, fq_count
    );
endinterface

// File: rtl/u_ifu_fetch_queue.sv
// rtl/u_ifu_fetch_queue.sv - fetch packet queue feeding decode one instruction per cycle
module u_ifu_fetch_queue #(
    parameter int DEPTH      = 4,
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    u_ifu_fetch_queue_if.slave fq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PC_WIDTH-1:0]   mem_pc    [DEPTH];
    logic [INST_WIDTH-1:0] mem_inst0 [DEPTH];
    logic [INST_WIDTH-1:0] mem_inst1 [DEPTH];
    logic                  mem_ua    [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          slot_sel;

    logic out_valid;
    logic push;
    logic consume;
    logic pop;

    assign fq.fq_in_ready = (count != CW'(DEPTH));
    assign out_valid      = (count != '0);
    assign fq.fq_out_valid = out_valid;
    assign fq.fq_count     = count;

    assign push    = fq.fq_in_valid & fq.fq_in_ready & ~fq.bru_flush;
    assign consume = out_valid & fq.fq_out_ready & ~fq.bru_flush;
    // Unaligned packets retire after slot 0; their second word is never decoded.
    assign pop     = consume & (slot_sel | mem_ua[rd_ptr]);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= fq.fq_in_pc;
            mem_inst0[wr_ptr] <= fq.fq_in_inst0;
            mem_inst1[wr_ptr] <= fq.fq_in_inst1;
            mem_ua[wr_ptr]    <= fq.fq_in_unalign;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || fq.bru_flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            slot_sel <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            if (consume) begin
                slot_sel <= ~pop;
            end
        end
    end

    always_comb begin
        fq.fq_out_pc      = '0;
        fq.fq_out_inst    = '0;
        fq.fq_out_unalign = 1'b0;
        if (out_valid) begin
            fq.fq_out_unalign = mem_ua[rd_ptr];
            if (slot_sel) begin
                fq.fq_out_pc   = mem_pc[rd_ptr] + PC_WIDTH'(4);
                fq.fq_out_inst = mem_inst1[rd_ptr];
            end else begin
                fq.fq_out_pc   = mem_pc[rd_ptr];
                fq.fq_out_inst = mem_inst0[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_u_ifu_fetch_queue.sv
// tb/tb_u_ifu_fetch_queue.sv - scoreboard bench for the fetch queue
module tb_u_ifu_fetch_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ua;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    int   nchk = 0;
    int   nerr = 0;
    int   mcount;
    logic in_acc;
    exp_t sb [$];
    exp_t e;

    always #5 clk = ~clk;

    u_ifu_fetch_queue_if #(.DEPTH(DEPTH), .PC_WIDTH(32), .INST_WIDTH(32)) fq_bus ();

    u_ifu_fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(32), .INST_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (fq_bus.slave)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each accepted packet becomes one or two decoded instructions;
    // occupancy is the number of packets whose final instruction is still queued.
    always @(negedge clk) begin
        if (chk_en) begin
            mcount = 0;
            foreach (sb[i]) if (sb[i].last) mcount++;
            chk("in_ready", 64'(fq_bus.fq_in_ready), 64'(mcount != DEPTH));
            chk("count", 64'(fq_bus.fq_count), 64'(mcount));
            chk("out_valid", 64'(fq_bus.fq_out_valid), 64'(sb.size() != 0));
            if (sb.size() != 0) begin
                chk("out_pc", 64'(fq_bus.fq_out_pc), 64'(sb[0].pc));
                chk("out_inst", 64'(fq_bus.fq_out_inst), 64'(sb[0].inst));
                chk("out_unalign", 64'(fq_bus.fq_out_unalign), 64'(sb[0].ua));
            end else begin
                chk("idle_pc", 64'(fq_bus.fq_out_pc), 64'd0);
                chk("idle_inst", 64'(fq_bus.fq_out_inst), 64'd0);
                chk("idle_unalign", 64'(fq_bus.fq_out_unalign), 64'd0);
            end
        end
        if (rst || fq_bus.bru_flush) begin
            sb.delete();
        end else begin
            mcount = 0;
            foreach (sb[i]) if (sb[i].last) mcount++;
            in_acc = fq_bus.fq_in_valid && (mcount != DEPTH);
            if (sb.size() != 0 && fq_bus.fq_out_ready) void'(sb.pop_front());
            if (in_acc) begin
                e.pc   = fq_bus.fq_in_pc;
                e.inst = fq_bus.fq_in_inst0;
                e.ua   = fq_bus.fq_in_unalign;
                e.last = fq_bus.fq_in_unalign;
                sb.push_back(e);
                if (!fq_bus.fq_in_unalign) begin
                    e.pc   = fq_bus.fq_in_pc + 32'd4;
                    e.inst = fq_bus.fq_in_inst1;
                    e.last = 1'b1;
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] i0,
                       input logic [31:0] i1, input logic ua, input logic rdy,
                       input logic fl, input logic r);
        fq_bus.fq_in_valid   = v;
        fq_bus.fq_in_pc      = pc;
        fq_bus.fq_in_inst0   = i0;
        fq_bus.fq_in_inst1   = i1;
        fq_bus.fq_in_unalign = ua;
        fq_bus.fq_out_ready  = rdy;
        fq_bus.bru_flush     = fl;
        rst                  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] rpc;
        logic        rua;
        cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Single packet, both slots, then empty
        cyc(1'b1, 32'h100, 32'hA, 32'hB, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 3);

        // Fill to full with decode stalled, reject a fifth, then free one entry
        for (int k = 0; k < 4; k++)
            cyc(1'b1, 32'h1000 + 32'(k * 16), 32'h10 + 32'(k), 32'h20 + 32'(k), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h2000, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h2000, 32'hDEAD, 32'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 10);

        // Unaligned packet presents slot 0 only
        cyc(1'b1, 32'h102, 32'h55, 32'h66, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h200, 32'h77, 32'h88, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 5);

        // Flush with three entries at slot 1 and a same-cycle push
        for (int k = 0; k < 3; k++)
            cyc(1'b1, 32'h3000 + 32'(k * 8), 32'h30 + 32'(k), 32'h40 + 32'(k), 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1);
        cyc(1'b1, 32'h4000, 32'h99, 32'h9A, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 32'h300, 32'hC0, 32'hC1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 3);

        // Continuous streaming across pointer wrap, including pc wraparound
        for (int k = 0; k < 3 * DEPTH; k++)
            cyc(1'b1, (k == 5) ? 32'hFFFF_FFFC : 32'h5000 + 32'(k * 8),
                32'h500 + 32'(k), 32'h600 + 32'(k), 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 2 * DEPTH + 2);

        // Reset while two entries are held, with a push on the same cycle
        cyc(1'b1, 32'h700, 32'h71, 32'h72, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h708, 32'h73, 32'h74, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h710, 32'h75, 32'h76, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(1'b1, 2);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            rua = ($urandom_range(0, 3) == 0);
            rpc = {$urandom()} & 32'hFFFF_FFFC;
            if (rua) rpc = rpc | 32'h2;
            cyc($urandom_range(0, 2) != 0, rpc, $urandom(), $urandom(), rua,
                $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
                $urandom_range(0, 79) == 0);
        end
        idle(1'b1, 2 * DEPTH + 2);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
